// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone cycle/burst codes, FSM states and burst address helper
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_e;

    // Linear bursts carry into every bit; wrap bursts increment only the low bits inside the wrap window.
    function automatic logic [31:0] burst_next(input logic [31:0] idx, input logic [1:0] bte);
        logic [31:0] mask;
        mask = (bte == BTE_WRAP4)  ? 32'd3  :
               (bte == BTE_WRAP8)  ? 32'd7  :
               (bte == BTE_WRAP16) ? 32'd15 : '1;
        return (idx & ~mask) | ((idx + 32'd1) & mask);
    endfunction

endpackage

// File: rtl/wb_ram_burst_bytemem.sv
// wb_ram_bytemem: DATA_W x DEPTH array with per-byte write enables and a registered read port
module wb_ram_bytemem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int AW     = 12,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [SEL_W-1:0]  we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    input  logic              rclr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes; the array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < SEL_W; n++)
            if (we_i[n])
                mem[waddr_i][8*n +: 8] <= wdata_i[8*n +: 8];
    end

    // Read register; cleared on reset and for addresses beyond the populated depth.
    always_ff @(posedge clk_i) begin
        if (rst_i || rclr_i)
            rdata_q <= '0;
        else
            rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ram_burst.sv
// wb_ram_burst: Wishbone B3 RAM slave with byte selects, registered-feedback bursts and range errors
module wb_ram_burst
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int AW     = 12,
    parameter int SEL_W  = DATA_W / 8,
    parameter int LSB    = $clog2(SEL_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic              wb_ack_o,
    output logic              wb_err_o
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e           state_q;
    logic             ack_q;
    logic             err_q;
    logic             req;
    logic             oor;
    logic [AW-1:0]    widx;
    logic [AW-1:0]    raddr;
    logic             rclr;
    logic [SEL_W-1:0] we;
    logic             unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign widx       = wb_adr_i[LSB+AW-1:LSB];
    assign oor        = {1'b0, widx} >= DEPTH_L;
    assign unused_adr = ^{wb_adr_i[31:LSB+AW], wb_adr_i[LSB-1:0]};

    // While a burst beat is being acked the master moves on, so prefetch the following word.
    assign raddr = (state_q == BURST && ack_q) ? AW'(burst_next(32'(widx), wb_bte_i)) : widx;
    assign rclr  = {1'b0, raddr} >= DEPTH_L;
    assign we    = (req && wb_we_i && !oor && !rst_i) ? wb_sel_i : '0;

    // Cycle-type FSM with registered ack/err terminations.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q   <= req & ~oor;
                    err_q   <= req & oor;
                    state_q <= !req ? IDLE : (oor || wb_cti_i != CTI_INCR) ? SINGLE : BURST;
                end
                SINGLE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                BURST: begin
                    if (!wb_cyc_i) begin
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (req && oor) begin
                        ack_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= SINGLE;
                    end else if (req && ack_q && wb_cti_i == CTI_EOB) begin
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        ack_q   <= req;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    wb_ram_bytemem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .SEL_W  (SEL_W)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we),
        .waddr_i (widx),
        .wdata_i (wb_dat_i),
        .raddr_i (raddr),
        .rclr_i  (rclr),
        .rdata_o (wb_dat_o)
    );

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_ram_burst.sv
// tb_wb_ram_burst: directed scoreboard bench for the Wishbone burst RAM
module tb_wb_ram_burst;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel = '1;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [2:0]  cti = 3'b000;
    logic [1:0]  bte = 2'b00;
    logic        ack;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        ack_s;
    logic        err_s;
    logic [31:0] dat_s;

    always #5 clk = ~clk;

    wb_ram_burst #(.DATA_W(32), .DEPTH(3000), .AW(12)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_ack_o (ack),
        .wb_err_o (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc1();
        @(negedge clk);
        ack_s = ack;
        err_s = err;
        dat_s = dat_o;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR; sel = '1;
    endtask

    task automatic classic(input string tag, input logic w, input int widx,
                           input logic [31:0] d, input logic [3:0] s, input logic exp_err);
        int n;
        logic [31:0] e;
        cyc = 1'b1; stb = 1'b1; we = w; adr = widx * 4; dat_i = d; sel = s; cti = CTI_CLASSIC;
        n = 0;
        do begin
            cyc1();
            n++;
        end while (!(ack_s || err_s) && n < 8);
        chk({tag, "_lat"}, n, 2);
        chk({tag, "_term"}, {ack_s, err_s}, exp_err ? 2'b01 : 2'b10);
        if (!w) begin
            e = exp_q.pop_front();
            if (ack_s || err_s) chk({tag, "_dat"}, dat_s, e);
        end
        bus_idle();
        cyc1();
        chk({tag, "_drop"}, {ack_s, err_s}, 2'b00);
    endtask

    task automatic burst_read(input string tag, input int w0, input int w1, input int w2,
                              input int w3, input logic [1:0] b, input int stall);
        int ws[4];
        int beat;
        int n;
        ws = '{w0, w1, w2, w3};
        cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = b; cti = CTI_INCR; adr = ws[0] * 4;
        beat = 0;
        n = 0;
        while (beat < 4 && n < 20) begin
            cyc1();
            n++;
            if (stb && ack_s) begin
                chk({tag, "_dat"}, dat_s, exp_q.pop_front());
                beat++;
                if (beat < 4) begin
                    adr = ws[beat] * 4;
                    cti = (beat == 3) ? CTI_EOB : CTI_INCR;
                end
                if (beat == stall) begin
                    stb = 1'b0;
                    cyc1(); n++;
                    cyc1(); n++;
                    chk({tag, "_ws_a"}, ack_s, 1'b0);
                    stb = 1'b1;
                    cyc1(); n++;
                    chk({tag, "_ws_b"}, ack_s, 1'b0);
                end
            end
        end
        chk({tag, "_beats"}, beat, 4);
        chk({tag, "_cycles"}, n, (stall < 0) ? 5 : 8);
        bus_idle();
        cyc1();
        chk({tag, "_eob"}, ack_s, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus_idle();
        rst = 1'b1;
        cyc1();
        cyc1();
        chk("rst_ack", ack_s, 1'b0);
        chk("rst_err", err_s, 1'b0);
        chk("rst_dat", dat_s, 32'h0);
        rst = 1'b0;
        cyc1();

        // master holds stb for three cycles on a classic write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat_i = 32'hDEADBEEF; sel = 4'hF;
        cyc1(); chk("hold_c1", ack_s, 1'b0);
        cyc1(); chk("hold_c2", ack_s, 1'b1);
        cyc1(); chk("hold_c3", ack_s, 1'b0);
        bus_idle();
        cyc1(); cyc1(); cyc1();
        exp_q.push_back(32'hDEADBEEF);
        classic("rd_w4", 1'b0, 4, 32'h0, 4'hF, 1'b0);

        // byte lanes
        classic("wr_w5", 1'b1, 5, 32'h11223344, 4'hF, 1'b0);
        classic("wr_w5_sel", 1'b1, 5, 32'hAABBCCDD, 4'b0101, 1'b0);
        exp_q.push_back(32'h11BB33DD);
        classic("rd_w5", 1'b0, 5, 32'h0, 4'hF, 1'b0);
        classic("wr_w5_sel0", 1'b1, 5, 32'h00000000, 4'b0000, 1'b0);
        exp_q.push_back(32'h11BB33DD);
        classic("rd_w5_sel0", 1'b0, 5, 32'h0, 4'hF, 1'b0);

        // linear burst over words 8..11
        for (int i = 0; i < 4; i++) classic("pre_lin", 1'b1, 8 + i, i, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        burst_read("lin", 8, 9, 10, 11, BTE_LINEAR, -1);

        // wrap-4 burst starting at word 6
        for (int i = 4; i < 8; i++) classic("pre_wrap", 1'b1, i, 32'h100 * i, 4'hF, 1'b0);
        exp_q.push_back(32'h600); exp_q.push_back(32'h700);
        exp_q.push_back(32'h400); exp_q.push_back(32'h500);
        burst_read("wrap4", 6, 7, 4, 5, BTE_WRAP4, -1);

        // master wait state after the second beat
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        burst_read("wait", 8, 9, 10, 11, BTE_LINEAR, 2);

        // out-of-range access at the first word past DEPTH
        classic("pre_2999", 1'b1, 2999, 32'h00002999, 4'hF, 1'b0);
        classic("pre_952", 1'b1, 952, 32'h00000952, 4'hF, 1'b0);
        classic("oor_wr", 1'b1, 3000, 32'hFFFFFFFF, 4'hF, 1'b1);
        exp_q.push_back(32'h0);
        classic("oor_rd", 1'b0, 3000, 32'h0, 4'hF, 1'b1);
        exp_q.push_back(32'h00002999);
        classic("rd_2999", 1'b0, 2999, 32'h0, 4'hF, 1'b0);
        exp_q.push_back(32'h00000952);
        classic("rd_952", 1'b0, 952, 32'h0, 4'hF, 1'b0);

        // reset in the middle of a write burst
        classic("pre_w20", 1'b1, 20, 32'h20, 4'hF, 1'b0);
        classic("pre_w21", 1'b1, 21, 32'h21, 4'hF, 1'b0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; cti = CTI_INCR; adr = 20 * 4; dat_i = 32'hA0A0A0A0;
        cyc1();
        cyc1();
        chk("rb_first_ack", ack_s, 1'b1);
        adr = 21 * 4; dat_i = 32'hB1B1B1B1; rst = 1'b1;
        cyc1();
        rst = 1'b0;
        bus_idle();
        cyc1();
        chk("rb_ack", ack_s, 1'b0);
        chk("rb_err", err_s, 1'b0);
        chk("rb_dat", dat_s, 32'h0);
        chk("rb_state", 32'(dut.state_q), 32'(IDLE));
        exp_q.push_back(32'hA0A0A0A0);
        classic("rd_w20", 1'b0, 20, 32'h0, 4'hF, 1'b0);
        exp_q.push_back(32'h21);
        classic("rd_w21", 1'b0, 21, 32'h0, 4'hF, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
